ex_stage_md: RTL

EX_STAGE_MD -- requirements
Module: ex_stage_md

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/md_unit.sv | 106 ++++++++++
 rtl/ex_stage_md.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, destination select and
// multiply/divide FSM states.
package mips_pkg;

  typedef enum logic [4:0] {
    OpAdd   = 5'd0,
    OpSub   = 5'd1,
    OpAnd   = 5'd2,
    OpOr    = 5'd3,
    OpXor   = 5'd4,
    OpNor   = 5'd5,
    OpSlt   = 5'd6,
    OpSltu  = 5'd7,
    OpSll   = 5'd8,
    OpSrl   = 5'd9,
    OpSra   = 5'd10,
    OpLui   = 5'd11,
    OpMult  = 5'd12,
    OpMultu = 5'd13,
    OpDiv   = 5'd14,
    OpDivu  = 5'd15,
    OpMfhi  = 5'd16,
    OpMflo  = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    DestRt    = 2'b00,
    DestRd    = 2'b01,
    DestLink  = 2'b10,
    DestRtAlt = 2'b11
  } dest_sel_e;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdRun  = 2'd1,
    MdDone = 2'd2
  } md_state_e;

  // Bit of the control sideband that carries register_write.
  localparam int unsigned CtrlWeBit = 0;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied when HI/LO are written.
module md_unit import mips_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CntW = $clog2(XLEN);

  md_state_e         state;
  logic [CntW-1:0]   cnt;
  logic              is_div, neg_q, neg_r;
  logic [XLEN-1:0]   work_a;   // multiplier, or dividend shifting into quotient
  logic [2*XLEN-1:0] work_b;   // shifting multiplicand, or divisor in low half
  logic [2*XLEN-1:0] acc;      // product, or remainder in low half
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              is_signed, is_div_op, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem, res_hi, res_lo;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    is_div_op = (op == OpDiv) || (op == OpDivu);
    is_signed = (op == OpMult) || (op == OpDiv);
    sign_a    = is_signed & a[XLEN-1];
    sign_b    = is_signed & b[XLEN-1];
    mag_a     = sign_a ? -a : a;
    mag_b     = sign_b ? -b : b;
    div_shift = {acc[XLEN-1:0], work_a[XLEN-1]};
    div_diff  = div_shift - {1'b0, work_b[XLEN-1:0]};
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -work_a : work_a;
    rem       = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    res_hi    = is_div ? rem : prod[2*XLEN-1:XLEN];
    res_lo    = is_div ? quo : prod[XLEN-1:0];
  end

  // HI/LO are forwarded during the write cycle so a read issued then sees the new value.
  assign hi = (state == MdDone) ? res_hi : hi_q;
  assign lo = (state == MdDone) ? res_lo : lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MdIdle;
      cnt    <= '0;
      busy   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      work_a <= '0;
      work_b <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        MdRun: begin
          if (is_div) begin
            acc    <= {{XLEN{1'b0}}, div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]};
            work_a <= {work_a[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            if (work_a[0]) acc <= acc + work_b;
            work_b <= work_b << 1;
            work_a <= work_a >> 1;
          end
          if (cnt == '0) begin
            state <= MdDone;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: begin
          if (state == MdDone) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          state <= MdIdle;
          if (start) begin
            state  <= MdRun;
            busy   <= 1'b1;
            cnt    <= CntW'(XLEN - 1);
            is_div <= is_div_op;
            // Divide by zero keeps the all-ones quotient unsigned.
            neg_q  <= (sign_a ^ sign_b) & ~(is_div_op & (b == '0));
            neg_r  <= sign_a;
            work_a <= is_div_op ? mag_a : mag_b;
            work_b <= {{XLEN{1'b0}}, is_div_op ? mag_b : mag_a};
            acc    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: combinational ALU, branch resolution and a registered EX/MEM
// output stage, with an attached iterative multiply/divide unit.
module ex_stage_md import mips_pkg::*; #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    rs_data,
  input  logic [XLEN-1:0]    rt_data,
  input  logic [XLEN-1:0]    imm_extend,
  input  logic [XLEN-1:0]    pc4,
  input  logic [4:0]         shamt,
  input  logic [4:0]         alu_op,
  input  logic               alu_src,
  input  logic [1:0]         dest_sel,
  input  logic [RADDR_W-1:0] rt_num,
  input  logic [RADDR_W-1:0] rd_field,
  input  logic               branch,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_rt_data,
  output logic [RADDR_W-1:0] out_rd_num,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic               branch_taken,
  output logic [XLEN-1:0]    branch_target,
  output logic               md_busy
);

  logic [XLEN-1:0]    op_b, alu_res, md_hi, md_lo;
  logic [RADDR_W-1:0] dest_num;
  logic [CTRL_W-1:0]  ctrl_next;
  logic               in_fire, md_op;

  // md_busy also covers MFHI/MFLO, which must wait for the running operation.
  assign in_ready = (~out_valid | out_ready) & ~md_busy;
  assign in_fire  = in_valid & in_ready;
  assign md_op    = is_md_op(alu_op);

  always_comb begin
    op_b    = alu_src ? imm_extend : rt_data;
    alu_res = '0;
    case (alu_op)
      OpAdd:   alu_res = rs_data + op_b;
      OpSub:   alu_res = rs_data - op_b;
      OpAnd:   alu_res = rs_data & op_b;
      OpOr:    alu_res = rs_data | op_b;
      OpXor:   alu_res = rs_data ^ op_b;
      OpNor:   alu_res = ~(rs_data | op_b);
      OpSlt:   alu_res[0] = $signed(rs_data) < $signed(op_b);
      OpSltu:  alu_res[0] = rs_data < op_b;
      OpSll:   alu_res = op_b << shamt;
      OpSrl:   alu_res = op_b >> shamt;
      OpSra:   alu_res = $unsigned($signed(op_b) >>> shamt);
      OpLui:   alu_res = op_b << 16;
      OpMfhi:  alu_res = md_hi;
      OpMflo:  alu_res = md_lo;
      default: alu_res = '0;
    endcase

    case (dest_sel)
      DestRd:   dest_num = rd_field;
      DestLink: dest_num = '1;
      default:  dest_num = rt_num;
    endcase

    // MD ops retire through the pipe with no register write; results land in HI/LO.
    ctrl_next = ctrl_in;
    if (md_op) ctrl_next[CtrlWeBit] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rt_data   <= '0;
      out_rd_num    <= '0;
      ctrl_out      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else if (in_fire) begin
      out_valid     <= 1'b1;
      out_result    <= alu_res;
      out_rt_data   <= rt_data;
      out_rd_num    <= dest_num;
      ctrl_out      <= ctrl_next;
      branch_taken  <= branch & (rs_data == op_b);
      branch_target <= pc4 + (imm_extend << 2);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  md_unit #(
    .XLEN (XLEN)
  ) u_md_unit (
    .clk   (clk),
    .rst   (rst),
    .start (in_fire & md_op),
    .op    (alu_op),
    .a     (rs_data),
    .b     (op_b),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

endmodule
